// File: rtl/axi_write_slave.sv
// AXI4 write-only slave that turns write bursts into single-port SRAM writes.
// Supports INCR and FIXED 32-bit bursts; any other burst answers SLVERR without writing.
module axi_write_slave #(
    parameter int unsigned AWORDS = 14,
    parameter logic [31:0] BASE   = 32'h0001_0000
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [7:0]        AWID_S,
    input  logic [31:0]       AWADDR_S,
    input  logic [3:0]        AWLEN_S,
    input  logic [2:0]        AWSIZE_S,
    input  logic [1:0]        AWBURST_S,
    input  logic              AWVALID_S,
    output logic              AWREADY_S,
    input  logic [31:0]       WDATA_S,
    input  logic [3:0]        WSTRB_S,
    input  logic              WLAST_S,
    input  logic              WVALID_S,
    output logic              WREADY_S,
    output logic [7:0]        BID_S,
    output logic [1:0]        BRESP_S,
    output logic              BVALID_S,
    input  logic              BREADY_S,
    output logic              CEB,
    output logic              WEB,
    output logic [31:0]       BWEB,
    output logic [AWORDS-1:0] A,
    output logic [31:0]       DI
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [AWORDS-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                incr_q;
    logic                bad_q;
    logic                oor_q;
    logic                err_q;

    logic [ADDR_W-1:0]   aw_off;
    logic                aw_bad;
    logic                aw_oor;
    logic                aw_hs;
    logic                w_hs;
    logic                cnt_last;
    logic                beat_last;
    logic                wr_en;
    logic [AWORDS:0]     addr_inc;
    logic                unused_c;

    assign aw_off    = AWADDR_S - BASE;
    assign aw_bad    = AWBURST_S[1] || (AWSIZE_S != 3'b010);
    // Start offset beyond the SRAM (including addresses below BASE, which wrap high).
    assign aw_oor    = |aw_off[ADDR_W-1:AWORDS+2];
    assign unused_c  = ^aw_off[1:0];

    assign aw_hs     = (state_q == IDLE) && AWVALID_S;
    assign w_hs      = (state_q == DATA) && WVALID_S;
    assign cnt_last  = (cnt_q == len_q);
    assign beat_last = WLAST_S || cnt_last;
    assign wr_en     = w_hs && !bad_q && !oor_q;
    assign addr_inc  = {1'b0, addr_q} + (AWORDS+1)'(1);

    assign AWREADY_S = (state_q == IDLE);
    assign WREADY_S  = (state_q == DATA);
    assign BVALID_S  = (state_q == RESP);
    assign BID_S     = id_q;
    assign BRESP_S   = {err_q, 1'b0};
    assign A         = addr_q;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and SRAM strobes.
    always_comb begin
        state_d = state_q;
        CEB     = 1'b1;
        WEB     = 1'b1;
        BWEB    = '1;
        DI      = '0;
        case (state_q)
            IDLE: if (AWVALID_S) state_d = DATA;
            DATA: begin
                if (wr_en) begin
                    CEB = 1'b0;
                    WEB = 1'b0;
                    DI  = WDATA_S;
                    for (int i = 0; i < int'(STRB_W); i++) begin
                        BWEB[8*i +: 8] = {8{~WSTRB_S[i]}};
                    end
                end
                if (w_hs && beat_last) state_d = RESP;
            end
            RESP: if (BREADY_S) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst context: latched at AW, advanced per beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q   <= '0;
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            incr_q <= 1'b0;
            bad_q  <= 1'b0;
            oor_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (aw_hs) begin
            id_q   <= AWID_S;
            addr_q <= aw_off[AWORDS+1:2];
            len_q  <= AWLEN_S;
            cnt_q  <= '0;
            incr_q <= (AWBURST_S == 2'b01);
            bad_q  <= aw_bad;
            oor_q  <= aw_oor;
            err_q  <= aw_bad || aw_oor;
        end else if (w_hs) begin
            cnt_q <= cnt_q + LEN_W'(1);
            if (incr_q) begin
                addr_q <= addr_inc[AWORDS-1:0];
                // Carry out of the word address means the next beat left the SRAM.
                if (addr_inc[AWORDS]) oor_q <= 1'b1;
            end
            if (bad_q || oor_q || (WLAST_S != cnt_last)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: per-scenario tasks with hand-computed expectations.
module tb_axi_write_slave;

    localparam int unsigned AWORDS = 14;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [7:0]        AWID_S;
    logic [31:0]       AWADDR_S;
    logic [3:0]        AWLEN_S;
    logic [2:0]        AWSIZE_S;
    logic [1:0]        AWBURST_S;
    logic              AWVALID_S;
    logic              AWREADY_S;
    logic [31:0]       WDATA_S;
    logic [3:0]        WSTRB_S;
    logic              WLAST_S;
    logic              WVALID_S;
    logic              WREADY_S;
    logic [7:0]        BID_S;
    logic [1:0]        BRESP_S;
    logic              BVALID_S;
    logic              BREADY_S;
    logic              CEB;
    logic              WEB;
    logic [31:0]       BWEB;
    logic [AWORDS-1:0] A;
    logic [31:0]       DI;

    int total = 0;
    int bad   = 0;

    axi_write_slave #(.AWORDS(AWORDS), .BASE(32'h0001_0000)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
        .BREADY_S(BREADY_S), .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI)
    );

    always #5 ACLK = ~ACLK;

    // {WREADY, CEB, WEB, A, DI, BWEB} sampled together for SRAM-side checks
    logic [80:0] sram_got;
    assign sram_got = {WREADY_S, CEB, WEB, A, DI, BWEB};

    // {AWREADY, WREADY, BVALID, BID, BRESP} for handshake-side checks
    logic [12:0] hs_got;
    assign hs_got = {AWREADY_S, WREADY_S, BVALID_S, BID_S, BRESP_S};

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(negedge ACLK);
        AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWSIZE_S = size; AWBURST_S = burst;
        AWVALID_S = 1'b1;
        @(negedge ACLK);
        AWVALID_S = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        WDATA_S = data; WSTRB_S = strb; WLAST_S = last; WVALID_S = 1'b1;
    endtask

    task automatic idle_w();
        WVALID_S = 1'b0; WLAST_S = 1'b0; WDATA_S = '0; WSTRB_S = '0;
    endtask

    task automatic test_reset();
        logic [80:0] exp_s;
        logic [12:0] exp_h;
        ARESETn = 1'b0;
        #1;
        exp_s = {1'b0, 1'b1, 1'b1, 14'd0, 32'd0, 32'hFFFF_FFFF};
        exp_h = {1'b1, 1'b0, 1'b0, 8'h00, 2'b00};
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL reset_sram got=%h exp=%h", sram_got, exp_s); end
        total++;
        if (hs_got !== exp_h) begin bad++; $display("FAIL reset_hs got=%h exp=%h", hs_got, exp_h); end
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        drive_w(32'hDEAD_BEEF, 4'hF, 1'b1);
        #1;
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL idle_w_no_access got=%h exp=%h", sram_got, exp_s); end
        @(negedge ACLK);
        idle_w();
        #1;
        total++;
        if (hs_got !== exp_h) begin bad++; $display("FAIL idle_w_stays_idle got=%h exp=%h", hs_got, exp_h); end
    endtask

    task automatic test_incr();
        logic [80:0] exp_s;
        do_aw(8'h15, 32'h0001_0010, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            drive_w(32'hA000_0000 + 32'(i), 4'hF, i == 3);
            #1;
            exp_s = {1'b1, 1'b0, 1'b0, 14'(4 + i), 32'hA000_0000 + 32'(i), 32'h0};
            total++;
            if (sram_got !== exp_s) begin bad++; $display("FAIL incr_beat%0d got=%h exp=%h", i, sram_got, exp_s); end
            @(negedge ACLK);
        end
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h15, 2'b00}) begin
            bad++; $display("FAIL incr_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h15, 2'b00});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
        #1;
        total++;
        if ({AWREADY_S, BVALID_S} !== 2'b10) begin bad++; $display("FAIL incr_b_done got=%b exp=10", {AWREADY_S, BVALID_S}); end
    endtask

    task automatic test_fixed();
        logic [80:0] exp_s;
        do_aw(8'h22, 32'h0001_0008, 4'd1, 3'b010, 2'b00);
        for (int i = 0; i < 2; i++) begin
            drive_w(32'h1234_5670 + 32'(i), 4'b0101, i == 1);
            #1;
            exp_s = {1'b1, 1'b0, 1'b0, 14'd2, 32'h1234_5670 + 32'(i), 32'hFF00_FF00};
            total++;
            if (sram_got !== exp_s) begin bad++; $display("FAIL fixed_beat%0d got=%h exp=%h", i, sram_got, exp_s); end
            @(negedge ACLK);
        end
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h22, 2'b00}) begin
            bad++; $display("FAIL fixed_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h22, 2'b00});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic test_early_last();
        logic [80:0] exp_s;
        do_aw(8'h31, 32'h0001_0000, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 2; i++) begin
            drive_w(32'hC0DE_0000 + 32'(i), 4'hF, i == 1);
            #1;
            exp_s = {1'b1, 1'b0, 1'b0, 14'(i), 32'hC0DE_0000 + 32'(i), 32'h0};
            total++;
            if (sram_got !== exp_s) begin bad++; $display("FAIL early_beat%0d got=%h exp=%h", i, sram_got, exp_s); end
            @(negedge ACLK);
        end
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h31, 2'b10}) begin
            bad++; $display("FAIL early_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h31, 2'b10});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic test_missing_last();
        logic [80:0] exp_s;
        do_aw(8'h44, 32'h0001_0040, 4'd1, 3'b010, 2'b01);
        for (int i = 0; i < 2; i++) begin
            drive_w(32'h5555_0000 + 32'(i), 4'hF, 1'b0);
            #1;
            exp_s = {1'b1, 1'b0, 1'b0, 14'(16 + i), 32'h5555_0000 + 32'(i), 32'h0};
            total++;
            if (sram_got !== exp_s) begin bad++; $display("FAIL nolast_beat%0d got=%h exp=%h", i, sram_got, exp_s); end
            @(negedge ACLK);
        end
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h44, 2'b10}) begin
            bad++; $display("FAIL nolast_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h44, 2'b10});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic test_wrap_err();
        logic [80:0] exp_s;
        do_aw(8'h5B, 32'h0001_0020, 4'd1, 3'b010, 2'b10);
        for (int i = 0; i < 2; i++) begin
            drive_w(32'hBAD0_0000 + 32'(i), 4'hF, i == 1);
            #1;
            exp_s = {1'b1, 1'b1, 1'b1, 14'd8, 32'h0, 32'hFFFF_FFFF};
            total++;
            if (sram_got !== exp_s) begin bad++; $display("FAIL wrap_beat%0d got=%h exp=%h", i, sram_got, exp_s); end
            @(negedge ACLK);
        end
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h5B, 2'b10}) begin
            bad++; $display("FAIL wrap_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h5B, 2'b10});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic test_oor();
        logic [80:0] exp_s;
        do_aw(8'h66, 32'h0001_FFFC, 4'd1, 3'b010, 2'b01);
        drive_w(32'h0F0F_0F0F, 4'hF, 1'b0);
        #1;
        exp_s = {1'b1, 1'b0, 1'b0, 14'h3FFF, 32'h0F0F_0F0F, 32'h0};
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL oor_top_word got=%h exp=%h", sram_got, exp_s); end
        @(negedge ACLK);
        drive_w(32'hF0F0_F0F0, 4'hF, 1'b1);
        #1;
        exp_s = {1'b1, 1'b1, 1'b1, 14'h0000, 32'h0, 32'hFFFF_FFFF};
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL oor_carry_beat got=%h exp=%h", sram_got, exp_s); end
        @(negedge ACLK);
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h66, 2'b10}) begin
            bad++; $display("FAIL oor_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h66, 2'b10});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    task automatic test_bready_hold();
        do_aw(8'h5A, 32'h0001_0030, 4'd0, 3'b010, 2'b01);
        drive_w(32'h0000_00AA, 4'hF, 1'b1);
        @(negedge ACLK);
        idle_w();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h5A, 2'b00}) begin
                bad++; $display("FAIL hold_cyc%0d got=%h exp=%h", i, hs_got, {1'b0, 1'b0, 1'b1, 8'h5A, 2'b00});
            end
            @(negedge ACLK);
        end
        BREADY_S = 1'b1;
        #1;
        total++;
        if (AWREADY_S !== 1'b0) begin bad++; $display("FAIL hold_awready_in_hs got=%b exp=0", AWREADY_S); end
        @(negedge ACLK);
        BREADY_S = 1'b0;
        #1;
        total++;
        if ({AWREADY_S, BVALID_S} !== 2'b10) begin bad++; $display("FAIL hold_after_hs got=%b exp=10", {AWREADY_S, BVALID_S}); end
    endtask

    task automatic test_reset_mid();
        logic [80:0] exp_s;
        do_aw(8'h70, 32'h0001_0020, 4'd3, 3'b010, 2'b01);
        drive_w(32'h1111_1111, 4'hF, 1'b0);
        #1;
        exp_s = {1'b1, 1'b0, 1'b0, 14'd8, 32'h1111_1111, 32'h0};
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL rstmid_beat0 got=%h exp=%h", sram_got, exp_s); end
        @(negedge ACLK);
        drive_w(32'h2222_2222, 4'hF, 1'b0);
        ARESETn = 1'b0;
        #1;
        exp_s = {1'b0, 1'b1, 1'b1, 14'd0, 32'h0, 32'hFFFF_FFFF};
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL rstmid_sram got=%h exp=%h", sram_got, exp_s); end
        total++;
        if (hs_got !== {1'b1, 1'b0, 1'b0, 8'h00, 2'b00}) begin
            bad++; $display("FAIL rstmid_hs got=%h exp=%h", hs_got, {1'b1, 1'b0, 1'b0, 8'h00, 2'b00});
        end
        @(negedge ACLK);
        idle_w();
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        total++;
        if (BVALID_S !== 1'b0) begin bad++; $display("FAIL rstmid_no_b got=%b exp=0", BVALID_S); end
        do_aw(8'h77, 32'h0001_0004, 4'd0, 3'b010, 2'b01);
        drive_w(32'h7777_7777, 4'b1000, 1'b1);
        #1;
        exp_s = {1'b1, 1'b0, 1'b0, 14'd1, 32'h7777_7777, 32'h00FF_FFFF};
        total++;
        if (sram_got !== exp_s) begin bad++; $display("FAIL rstmid_new_beat got=%h exp=%h", sram_got, exp_s); end
        @(negedge ACLK);
        idle_w();
        #1;
        total++;
        if (hs_got !== {1'b0, 1'b0, 1'b1, 8'h77, 2'b00}) begin
            bad++; $display("FAIL rstmid_new_resp got=%h exp=%h", hs_got, {1'b0, 1'b0, 1'b1, 8'h77, 2'b00});
        end
        BREADY_S = 1'b1;
        @(negedge ACLK);
        BREADY_S = 1'b0;
    endtask

    initial begin
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = 3'b010; AWBURST_S = 2'b01;
        AWVALID_S = 1'b0; BREADY_S = 1'b0;
        idle_w();
        test_reset();
        test_incr();
        test_fixed();
        test_early_last();
        test_missing_last();
        test_wrap_err();
        test_oor();
        test_bready_hold();
        test_reset_mid();
        repeat (2) @(negedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
